// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop framing with integrated baud tick divider.
// Latency: start seen 3 sys_clk after the line falls; rx_dout/rx_done_tick update STOP_BIT_TICKS ticks after the last data sample.
// Backpressure: none; rx_done_tick is a one-cycle strobe and rx_dout holds until the next valid frame.
module uart_rx #(
  parameter int BAUD_RATE      = 9600,
  parameter int SYS_CLK_FREQ   = 100000000,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BIT_TICKS = 16
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rx_data_in,
  output logic                 rx_done_tick,
  output logic [DATA_BITS-1:0] rx_dout
);

  localparam int DIV = SYS_CLK_FREQ / (16 * BAUD_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int NW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          tick_cnt_q, tick_cnt_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic [3:0]             s_cnt_q, s_cnt_d;
  logic [NW-1:0]          n_cnt_q, n_cnt_d;
  logic [DATA_BITS-1:0]   b_reg_q, b_reg_d;
  logic [DATA_BITS-1:0]   rx_dout_q, rx_dout_d;
  logic                   done_q, done_d;
  logic                   tick;
  logic                   rx_s;

  // One oversampling tick per DIV sys_clk cycles, on the last count before wrap.
  assign tick = (tick_cnt_q == CW'(DIV - 1));
  assign rx_s = sync2_q;

  // Free-running tick divider and two-flop synchronizer for the asynchronous line.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
    sync1_d    = rx_data_in;
    sync2_d    = sync1_q;
  end

  // Framing FSM: count ticks to the middle of each bit and sample there.
  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    n_cnt_d   = n_cnt_q;
    b_reg_d   = b_reg_q;
    rx_dout_d = rx_dout_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // Arm on a low level at any cycle, not only on ticks.
        if (!rx_s) begin
          s_cnt_d = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt_q == 4'd7) begin
            if (!rx_s) begin
              s_cnt_d = '0;
              n_cnt_d = '0;
              state_d = DATA;
            end else begin
              // Line went back high before mid start: treat as a glitch.
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_cnt_q == 4'd15) begin
            b_reg_d = {rx_s, b_reg_q[DATA_BITS-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == NW'(DATA_BITS - 1)) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_cnt_q == 4'(STOP_BIT_TICKS - 1)) begin
            // A low stop bit is a framing error: drop the word silently.
            if (rx_s) begin
              rx_dout_d = b_reg_q;
              done_d    = 1'b1;
            end
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; synchronous reset wins over everything, including mid-frame.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      s_cnt_q    <= '0;
      n_cnt_q    <= '0;
      b_reg_q    <= '0;
      rx_dout_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      s_cnt_q    <= s_cnt_d;
      n_cnt_q    <= n_cnt_d;
      b_reg_q    <= b_reg_d;
      rx_dout_q  <= rx_dout_d;
      done_q     <= done_d;
    end
  end

  assign rx_done_tick = done_q;
  assign rx_dout      = rx_dout_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scaled-clock instance for framing scenarios, default instance for tick spacing.
// Latency: frames take about ten transmit bit times each; the tick check spans three default ticks.
// Backpressure: none; every done pulse is captured by a monitor on the falling clock edge.
`timescale 1ns/1ps
module tb_uart_rx;

  // Scaled instance: DIV = 1536000 / (16*9600) = 10, so one receive bit = 160 sys_clk.
  localparam int SCL_FREQ = 1536000;
  // Transmit bit time 157 cycles: about 1.9% fast against the 160-cycle receive bit.
  localparam int TXB = 157;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rx_done_tick;
  logic [7:0] rx_dout;
  logic       def_line = 1'b1;
  logic       def_done;
  logic [7:0] def_dout;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] rxq[$];
  int run_len = 0;

  always #5 clk = ~clk;

  uart_rx #(.BAUD_RATE(9600), .SYS_CLK_FREQ(SCL_FREQ), .DATA_BITS(8), .STOP_BIT_TICKS(16)) dut (
    .sys_clk(clk), .rst(rst), .rx_data_in(rx), .rx_done_tick(rx_done_tick), .rx_dout(rx_dout));

  uart_rx dut_def (
    .sys_clk(clk), .rst(rst), .rx_data_in(def_line), .rx_done_tick(def_done), .rx_dout(def_dout));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every received word and confirm each done pulse lasts one cycle.
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      if (run_len == 0) rxq.push_back(rx_dout);
      run_len++;
    end else if (run_len > 0) begin
      check("done_width", run_len, 1);
      run_len = 0;
    end
  end

  task automatic idle_bits(input int nbits);
    rx = 1'b1;
    repeat (nbits * TXB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    rx = 1'b0;
    repeat (TXB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (TXB) @(negedge clk);
    end
    rx = stop_v;
    repeat (TXB) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    int n;
    int nhigh;
    int tidx[3];
    for (int i = 0; i < 3; i++) tidx[i] = -1000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_done", rx_done_tick, 0);
    check("rst_dout", rx_dout, 8'h00);
    rst = 1'b0;

    // Default tick: first tick consumed on edge 651, then every 651 cycles, one cycle wide.
    n = 0;
    nhigh = 0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      n++;
      if (dut_def.tick === 1'b1) begin
        if (nhigh < 3) tidx[nhigh] = n;
        nhigh++;
      end
    end
    check("tick_first", tidx[0] + 1, 651);
    check("tick_space1", tidx[1] - tidx[0], 651);
    check("tick_space2", tidx[2] - tidx[1], 651);
    check("tick_count", nhigh, 3);

    // Line bits 1,0,0,1,1,0,1,0 -> 0x59
    rxq.delete();
    idle_bits(1);
    send_frame(8'h59, 1'b1);
    check("f59_pulses", rxq.size(), 1);
    if (rxq.size() > 0) check("f59_data", rxq[0], 8'h59);
    repeat (TXB / 2) @(negedge clk);
    check("f59_stable", rx_dout, 8'h59);

    // Back-to-back frames with a single stop bit between them
    rxq.delete();
    idle_bits(1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_bits(1);
    check("b2b_pulses", rxq.size(), 2);
    if (rxq.size() == 2) begin
      check("b2b_first", rxq[0], 8'h00);
      check("b2b_second", rxq[1], 8'hFF);
    end

    // Short low glitch on an idle line: rejected at mid-start
    rxq.delete();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    idle_bits(2);
    check("glitch_pulses", rxq.size(), 0);
    check("glitch_dout", rx_dout, 8'hFF);

    // Framing error on 0xA5, then a valid 0x3C
    rxq.delete();
    send_frame(8'hA5, 1'b0);
    idle_bits(2);
    check("ferr_pulses", rxq.size(), 0);
    check("ferr_dout", rx_dout, 8'hFF);
    send_frame(8'h3C, 1'b1);
    idle_bits(1);
    check("f3c_pulses", rxq.size(), 1);
    check("f3c_dout", rx_dout, 8'h3C);

    // Reset for two cycles in the middle of data bit 3 of an all-ones frame
    rxq.delete();
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (4 * TXB + TXB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("midrst_done", rx_done_tick, 0);
        check("midrst_dout", rx_dout, 8'h00);
      end
    join
    idle_bits(1);
    check("midrst_pulses", rxq.size(), 0);
    check("midrst_hold", rx_dout, 8'h00);
    send_frame(8'h81, 1'b1);
    idle_bits(1);
    check("f81_pulses", rxq.size(), 1);
    check("f81_dout", rx_dout, 8'h81);

    // Default instance saw an idle line throughout
    check("def_dout", def_dout, 8'h00);
    check("def_done", def_done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
